// File: rtl/aes_key_schedule.sv
// Iterative AES key scheduler: expands a 128/192/256-bit cipher key one 32-bit word per
// clock into an internal word store and serves 128-bit round keys through an indexed port.
// Define AES_KEY_256_EN to enable AES-256 (60-word store, 8-word window, i mod 8 = 4 path);
// without it key_len=2 is rejected as illegal.

module s_box (
    input  logic [3:0] i_hi,
    input  logic [3:0] i_lo,
    output logic [7:0] o_byte
);
    logic [7:0] w_in;
    logic [7:0] w_sq;
    logic [7:0] w_inv;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the AES affine transform
    always_comb begin
        w_in  = {i_hi, i_lo};
        w_sq  = w_in;
        w_inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            w_sq  = gf_mul(w_sq, w_sq);
            w_inv = gf_mul(w_inv, w_sq);
        end
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_schedule #(
    parameter int unsigned RD_REG = 1,
    parameter int unsigned KEY_W  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [0:KEY_W-1] key_in,
    input  logic [3:0]       rd_idx,
    output logic [0:127]     rd_key,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic             key_err
);
`ifdef AES_KEY_256_EN
    localparam int unsigned NWORDS = 60;
    localparam int unsigned WIN    = 8;
`else
    localparam int unsigned NWORDS = 52;
    localparam int unsigned WIN    = 6;
    logic w_unused_key;
    assign w_unused_key = ^key_in[192:KEY_W-1];
`endif

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_nk, r_nr;
    logic [5:0]  r_i;
    logic [2:0]  r_cnt;          // i mod Nk, tracked incrementally
    logic [7:0]  r_rcon;
    logic        r_done, r_valid, r_err;
    logic [31:0] r_win [WIN];    // newest word at WIN-1, w[i-Nk] at WIN-Nk
    logic [31:0] r_store [NWORDS];

    logic        w_legal, w_accept, w_reject, w_last;
    logic [3:0]  w_nk, w_nr;
    logic [2:0]  w_old_idx;
    logic [5:0]  w_last_i;
    logic [31:0] w_prev, w_rot, w_sb_in, w_sb_out, w_temp, w_new;
    logic [5:0]  w_base;
    logic [0:127] w_rd;

    // Decode the requested key size; anything unsupported is illegal
    always_comb begin
        w_legal = 1'b1;
        w_nk    = 4'd4;
        w_nr    = 4'd10;
        case (key_len)
            2'd0: ;
            2'd1: begin
                w_nk = 4'd6;
                w_nr = 4'd12;
            end
`ifdef AES_KEY_256_EN
            2'd2: begin
                w_nk = 4'd8;
                w_nr = 4'd14;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == StIdle) && start && w_legal;
    assign w_reject  = (r_state == StIdle) && start && !w_legal;
    assign w_last_i  = {r_nr, 2'b00} + 6'd3;
    assign w_last    = (r_state == StExpand) && (r_i == w_last_i);
    // Modulo-8 wrap makes WIN-Nk come out right for every legal Nk
    assign w_old_idx = 3'(WIN) - r_nk[2:0];
    assign w_prev    = r_win[WIN-1];
    assign w_rot     = {w_prev[23:0], w_prev[31:24]};
    assign w_sb_in   = (r_cnt == 3'd0) ? w_rot : w_prev;

    s_box u_sbox0 (.i_hi(w_sb_in[31:28]), .i_lo(w_sb_in[27:24]), .o_byte(w_sb_out[31:24]));
    s_box u_sbox1 (.i_hi(w_sb_in[23:20]), .i_lo(w_sb_in[19:16]), .o_byte(w_sb_out[23:16]));
    s_box u_sbox2 (.i_hi(w_sb_in[15:12]), .i_lo(w_sb_in[11:8]),  .o_byte(w_sb_out[15:8]));
    s_box u_sbox3 (.i_hi(w_sb_in[7:4]),   .i_lo(w_sb_in[3:0]),   .o_byte(w_sb_out[7:0]));

    // Next expanded word from the window only
    always_comb begin
        w_temp = w_prev;
        if (r_cnt == 3'd0) begin
            w_temp = w_sb_out ^ {r_rcon, 24'h000000};
        end
`ifdef AES_KEY_256_EN
        else if (r_nk == 4'd8 && r_cnt == 3'd4) begin
            w_temp = w_sb_out;
        end
`endif
        w_new = r_win[w_old_idx] ^ w_temp;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_next = StExpand;
            StExpand: if (w_last) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Control state, counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_nk    <= 4'd0;
            r_nr    <= 4'd0;
            r_i     <= 6'd0;
            r_cnt   <= 3'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_reject) r_err <= 1'b1;
            if (w_accept) begin
                r_nk    <= w_nk;
                r_nr    <= w_nr;
                r_i     <= {2'b00, w_nk};
                r_cnt   <= 3'd0;
                r_rcon  <= 8'h01;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end else if (r_state == StExpand) begin
                r_i   <= r_i + 6'd1;
                r_cnt <= ({1'b0, r_cnt} == r_nk - 4'd1) ? 3'd0 : r_cnt + 3'd1;
                if (r_cnt == 3'd0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
                if (w_last) begin
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // Word store and sliding window: load key words, then append one word per cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < int'(WIN); k++) begin
                if (k < int'(w_nk)) begin
                    r_win[3'(WIN - int'(w_nk) + k)] <= key_in[32*k +: 32];
                    r_store[k] <= key_in[32*k +: 32];
                end
            end
        end else if (r_state == StExpand) begin
            for (int k = 0; k < int'(WIN) - 1; k++) begin
                r_win[k] <= r_win[k+1];
            end
            r_win[WIN-1] <= w_new;
            r_store[r_i] <= w_new;
        end
    end

    // Round-key read mux; out-of-range index or incomplete set reads as zero
    always_comb begin
        w_base = {rd_idx, 2'b00};
        w_rd   = '0;
        if (r_valid && rd_idx <= r_nr) begin
            w_rd = {r_store[w_base], r_store[w_base + 6'd1],
                    r_store[w_base + 6'd2], r_store[w_base + 6'd3]};
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [0:127] r_rd;
            // Registered read; a new start blanks the port at once
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_rd <= '0;
                else     r_rd <= w_accept ? '0 : w_rd;
            end
            assign rd_key = r_rd;
        end else begin : g_rd_comb
            assign rd_key = w_rd;
        end
    endgenerate

    assign busy       = (r_state == StExpand);
    assign done       = r_done;
    assign keys_valid = r_valid;
    assign key_err    = r_err;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer vectors, random keys against a
// FIPS-197 style reference expansion, illegal inputs, reset, ignored starts, back-to-back.
module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [0:255] key_in;
    logic [3:0]   rd_idx;
    logic [0:127] rd_key;
    logic         busy, done, keys_valid, key_err;

    int errors = 0;
    int checks = 0;
    logic [7:0]  sbox  [256];
    logic [31:0] ref_w [60];

    aes_key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .rd_idx(rd_idx), .rd_key(rd_key), .busy(busy), .done(done),
        .keys_valid(keys_valid), .key_err(key_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox;
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic compute_ref(input logic [0:255] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) ref_w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [0:127] ref_key(input int idx);
        return {ref_w[4*idx], ref_w[4*idx+1], ref_w[4*idx+2], ref_w[4*idx+3]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] len, input logic [0:255] key);
        key_len = len; key_in = key; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            tick;
            n++;
            if (done) break;
        end
    endtask

    task automatic read_key(input int idx, output logic [0:127] v);
        rd_idx = 4'(idx);
        tick;
        v = rd_key;
    endtask

    function automatic logic [0:255] rand_key;
        logic [0:255] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 0; key_len = 0; key_in = '0; rd_idx = 0;
        tick; tick;
        checks++;
        if ({busy, done, keys_valid, key_err} !== 4'b0000 || rd_key !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b err=%b rd_key=%h, want all 0",
                     busy, done, keys_valid, key_err, rd_key);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_kat128;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n;
        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        compute_ref(key, 4);
        do_start(2'd0, key);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL k128_busy: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n != 40 || keys_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL k128_done: got %0d cycles valid=%b busy=%b, want 40 1 0", n, keys_valid, busy);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL k128_done_pulse: got %b want 0", done); end
        read_key(1, v);
        checks++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL k128_idx1: got %h want a0fafe1788542cb123a339392a6c7605", v);
        end
        read_key(10, v);
        checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL k128_idx10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
        for (int idx = 0; idx < 16; idx++) begin
            read_key(idx, v);
            exp = (idx <= 10) ? ref_key(idx) : '0;
            checks++;
            if (v !== exp) begin errors++; $display("FAIL k128_all[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask

    task automatic test_kat192;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n;
        key = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        compute_ref(key, 6);
        do_start(2'd1, key);
        wait_done(n);
        checks++;
        if (n != 46) begin errors++; $display("FAIL k192_done: got %0d cycles want 46", n); end
        read_key(12, v);
        checks++;
        if (v !== 128'he98ba06f448c773c8ecc720401002202) begin
            errors++; $display("FAIL k192_idx12: got %h want e98ba06f448c773c8ecc720401002202", v);
        end
        for (int idx = 0; idx < 16; idx++) begin
            read_key(idx, v);
            exp = (idx <= 12) ? ref_key(idx) : '0;
            checks++;
            if (v !== exp) begin errors++; $display("FAIL k192_all[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask

`ifdef AES_KEY_256_EN
    task automatic test_kat256;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n;
        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        compute_ref(key, 8);
        do_start(2'd2, key);
        wait_done(n);
        checks++;
        if (n != 52) begin errors++; $display("FAIL k256_done: got %0d cycles want 52", n); end
        read_key(14, v);
        checks++;
        if (v !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++; $display("FAIL k256_idx14: got %h want fe4890d1e6188d0b046df344706c631e", v);
        end
        for (int idx = 0; idx < 16; idx++) begin
            read_key(idx, v);
            exp = (idx <= 14) ? ref_key(idx) : '0;
            checks++;
            if (v !== exp) begin errors++; $display("FAIL k256_all[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask
`else
    task automatic test_len2_illegal;
        do_start(2'd2, rand_key());
        checks++;
        if (key_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL len2_illegal: got err=%b busy=%b want 1 0", key_err, busy);
        end
    endtask
`endif

    task automatic test_illegal;
        do_start(2'd3, rand_key());
        checks++;
        if (key_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL len3_illegal: got err=%b busy=%b want 1 0", key_err, busy);
        end
        tick; tick;
        checks++;
        if (key_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL len3_sticky: got err=%b busy=%b want 1 0", key_err, busy);
        end
    endtask

    task automatic test_random;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n, len, nk, nr, maxlen;
`ifdef AES_KEY_256_EN
        maxlen = 2;
`else
        maxlen = 1;
`endif
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(0, maxlen);
            nk = 4 + 2 * len; nr = nk + 6;
            key = rand_key();
            compute_ref(key, nk);
            do_start(2'(len), key);
            checks++;
            if (key_err !== 1'b0 || keys_valid !== 1'b0) begin
                errors++; $display("FAIL rand_start_clear[%0d]: got err=%b valid=%b want 0 0",
                                   it, key_err, keys_valid);
            end
            wait_done(n);
            checks++;
            if (n != 4 * (nr + 1) - nk) begin
                errors++; $display("FAIL rand_done[%0d]: got %0d cycles want %0d", it, n, 4*(nr+1)-nk);
            end
            for (int idx = 0; idx < 16; idx++) begin
                read_key(idx, v);
                exp = (idx <= nr) ? ref_key(idx) : '0;
                checks++;
                if (v !== exp) begin
                    errors++; $display("FAIL rand[%0d]_key[%0d]: got %h want %h", it, idx, v, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n;
        rd_idx = 4'd1;
        do_start(2'd1, rand_key());
        repeat (19) tick;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, keys_valid, key_err} !== 4'b0000 || rd_key !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b valid=%b err=%b rd_key=%h, want all 0",
                     busy, done, keys_valid, key_err, rd_key);
        end
        tick;
        rst = 1'b0;
        tick;
        key = rand_key();
        compute_ref(key, 4);
        do_start(2'd0, key);
        wait_done(n);
        checks++;
        if (n != 40) begin errors++; $display("FAIL reset_restart_done: got %0d want 40", n); end
        for (int idx = 0; idx <= 10; idx++) begin
            read_key(idx, v);
            exp = ref_key(idx);
            checks++;
            if (v !== exp) begin errors++; $display("FAIL reset_restart[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask

    task automatic test_start_ignored;
        logic [0:255] key;
        logic [0:127] v, exp;
        int n;
        key = rand_key();
        compute_ref(key, 4);
        do_start(2'd0, key);
        repeat (10) tick;
        key_len = 2'($urandom_range(1, 3)); key_in = rand_key(); start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(n);
        checks++;
        if (n + 11 != 40 || key_err !== 1'b0) begin
            errors++; $display("FAIL ignored_start: got %0d cycles err=%b want 40 0", n + 11, key_err);
        end
        for (int idx = 0; idx <= 10; idx++) begin
            read_key(idx, v);
            exp = ref_key(idx);
            checks++;
            if (v !== exp) begin errors++; $display("FAIL ignored_keys[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask

    task automatic test_back_to_back;
        logic [0:255] key_b;
        logic [0:127] v, exp;
        int n;
        do_start(2'd0, rand_key());
        wait_done(n);
        key_b = rand_key();
        compute_ref(key_b, 6);
        rd_idx = 4'd1;
        do_start(2'd1, key_b);
        checks++;
        if (keys_valid !== 1'b0 || busy !== 1'b1 || rd_key !== '0) begin
            errors++; $display("FAIL b2b_accept: got valid=%b busy=%b rd_key=%h want 0 1 0",
                               keys_valid, busy, rd_key);
        end
        wait_done(n);
        checks++;
        if (n != 46) begin errors++; $display("FAIL b2b_done: got %0d want 46", n); end
        for (int idx = 0; idx <= 12; idx++) begin
            read_key(idx, v);
            exp = ref_key(idx);
            checks++;
            if (v !== exp) begin errors++; $display("FAIL b2b_keys[%0d]: got %h want %h", idx, v, exp); end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_kat128();
        test_kat192();
`ifdef AES_KEY_256_EN
        test_kat256();
`else
        test_len2_illegal();
`endif
        test_illegal();
        test_random();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
